ascii2scan_seq: RTL

- Converts one ASCII character per request into the complete PS/2 set-2 keystroke byte sequence (make code, then break code), with shift wrapping for upper-case letters.
- Hands the bytes one at a time to the PS/2 transmitter through its write-strobe / idle / done handshake.
- Sits between a character source (UART receive FIFO or text buffer) and the PS/2 transmitter. It is the keyboard-emulation counterpart of the scan-code-to-ASCII decoder.

---
 rtl/ps2_pkg.sv | 61 ++++++
 rtl/ascii2scan_lut.sv | 46 ++++
 rtl/ascii2scan_seq.sv | 110 +++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// PS/2 set-2 constants, sequencer state type and keystroke byte ordering,
// shared by the ASCII-to-scan sequencer and the scan-to-ASCII decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_DONE,
    ST_GAP
  } seq_state_t;

  // Index 0 is 'A' / '0'; the concatenation lists the highest index first.
  localparam logic [25:0][7:0] SET2_LETTER = {
    8'h1A, 8'h35, 8'h22, 8'h1D, 8'h2A, 8'h3C, 8'h2C, 8'h1B, 8'h2D, 8'h15,
    8'h4D, 8'h44, 8'h31, 8'h3A, 8'h4B, 8'h42, 8'h3B, 8'h43, 8'h33, 8'h34,
    8'h2B, 8'h24, 8'h23, 8'h21, 8'h32, 8'h1C
  };
  localparam logic [9:0][7:0] SET2_DIGIT = {
    8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
  };

  localparam logic [7:0] SET2_BACKTICK  = 8'h0E;
  localparam logic [7:0] SET2_MINUS     = 8'h4E;
  localparam logic [7:0] SET2_EQUAL     = 8'h55;
  localparam logic [7:0] SET2_LBRACKET  = 8'h54;
  localparam logic [7:0] SET2_RBRACKET  = 8'h5B;
  localparam logic [7:0] SET2_BACKSLASH = 8'h5D;
  localparam logic [7:0] SET2_SEMICOLON = 8'h4C;
  localparam logic [7:0] SET2_QUOTE     = 8'h52;
  localparam logic [7:0] SET2_COMMA     = 8'h41;
  localparam logic [7:0] SET2_PERIOD    = 8'h49;
  localparam logic [7:0] SET2_SLASH     = 8'h4A;
  localparam logic [7:0] SET2_SPACE     = 8'h29;
  localparam logic [7:0] SET2_ENTER     = 8'h5A;
  localparam logic [7:0] SET2_BKSP      = 8'h66;

  // Byte idx of a keystroke: make/BRK/make, or wrapped in left-shift press/release.
  function automatic logic [7:0] seq_byte(input logic [2:0] idx,
                                          input logic [7:0] make,
                                          input logic       shift);
    logic [7:0] b;
    b = make;
    if (shift) begin
      case (idx)
        3'd0:    b = PS2_LSHIFT;
        3'd1:    b = make;
        3'd2:    b = PS2_BRK;
        3'd3:    b = make;
        3'd4:    b = PS2_BRK;
        default: b = PS2_LSHIFT;
      endcase
    end else if (idx == 3'd1) begin
      b = PS2_BRK;
    end
    return b;
  endfunction

endpackage

// File: rtl/ascii2scan_lut.sv
// Combinational ASCII to PS/2 set-2 make-code lookup with shift flag.
module ascii2scan_lut (
  input  logic [7:0] ascii_code,
  output logic [7:0] make,
  output logic       shift,
  output logic       valid
);
  import ps2_pkg::*;

  // Letters share their low five bits between cases: 'a'/'A' = 1.
  logic [4:0] letter_idx;
  assign letter_idx = ascii_code[4:0] - 5'd1;

  always_comb begin
    make  = '0;
    shift = 1'b0;
    valid = 1'b1;
    if (ascii_code inside {[8'h61:8'h7A]}) begin
      make = SET2_LETTER[letter_idx];
    end else if (ascii_code inside {[8'h41:8'h5A]}) begin
      make  = SET2_LETTER[letter_idx];
      shift = 1'b1;
    end else if (ascii_code inside {[8'h30:8'h39]}) begin
      make = SET2_DIGIT[ascii_code[3:0]];
    end else begin
      case (ascii_code)
        8'h60:   make = SET2_BACKTICK;
        8'h2D:   make = SET2_MINUS;
        8'h3D:   make = SET2_EQUAL;
        8'h5B:   make = SET2_LBRACKET;
        8'h5D:   make = SET2_RBRACKET;
        8'h5C:   make = SET2_BACKSLASH;
        8'h3B:   make = SET2_SEMICOLON;
        8'h27:   make = SET2_QUOTE;
        8'h2C:   make = SET2_COMMA;
        8'h2E:   make = SET2_PERIOD;
        8'h2F:   make = SET2_SLASH;
        8'h20:   make = SET2_SPACE;
        8'h0D:   make = SET2_ENTER;
        8'h08:   make = SET2_BKSP;
        default: valid = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ascii2scan_seq.sv
// Turns one ASCII character into its full PS/2 keystroke byte sequence and
// feeds it byte by byte to the PS/2 transmitter, with an idle gap per byte.
module ascii2scan_seq #(
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii_code,
  input  logic       wr_ascii,
  output logic       rdy,
  output logic [7:0] scan_code,
  output logic       wr_scan,
  input  logic       tx_idle,
  input  logic       tx_done_tick,
  output logic       unmapped_tick
);
  import ps2_pkg::*;

  seq_state_t  state;
  logic [2:0]  idx;
  logic [15:0] cnt;
  logic [7:0]  make_q;
  logic        shift_q;

  logic [7:0]  lut_make;
  logic        lut_shift;
  logic        lut_valid;

  logic        advance;
  logic        last_byte;
  logic [2:0]  next_idx;

  ascii2scan_lut u_lut (
    .ascii_code (ascii_code),
    .make       (lut_make),
    .shift      (lut_shift),
    .valid      (lut_valid)
  );

  assign wr_scan   = (state == ST_SEND) && tx_idle;
  assign last_byte = (idx == (shift_q ? 3'd5 : 3'd2));
  assign next_idx  = idx + 3'd1;

  // A zero gap makes the byte decision directly on tx_done_tick.
  always_comb begin
    advance = 1'b0;
    if (state == ST_WAIT_DONE && tx_done_tick && GAP_CYCLES == 0)
      advance = 1'b1;
    if (state == ST_GAP && cnt <= 16'd1)
      advance = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      rdy           <= 1'b1;
      scan_code     <= '0;
      unmapped_tick <= 1'b0;
      idx           <= '0;
      cnt           <= '0;
      make_q        <= '0;
      shift_q       <= 1'b0;
    end else begin
      unmapped_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_ascii) begin
            if (lut_valid) begin
              make_q    <= lut_make;
              shift_q   <= lut_shift;
              idx       <= '0;
              scan_code <= seq_byte(3'd0, lut_make, lut_shift);
              rdy       <= 1'b0;
              state     <= ST_SEND;
            end else begin
              unmapped_tick <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (tx_idle)
            state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (tx_done_tick && GAP_CYCLES != 0) begin
            cnt   <= GAP_CYCLES[15:0];
            state <= ST_GAP;
          end
        end
        ST_GAP: cnt <= cnt - 16'd1;
        default: begin
          state <= ST_IDLE;
          rdy   <= 1'b1;
        end
      endcase

      if (advance) begin
        if (last_byte) begin
          state <= ST_IDLE;
          rdy   <= 1'b1;
        end else begin
          idx       <= next_idx;
          scan_code <= seq_byte(next_idx, make_q, shift_q);
          state     <= ST_SEND;
        end
      end
    end
  end

endmodule
